// File: rtl/renode_axi_pkg.sv
// Shared types for the Renode AXI register bridge: AXI response codes and bridge FSM states.
// No logic, no latency, no flow control of its own.
package renode_axi_pkg;

    typedef enum logic [1:0] {
        Okay                = 2'd0,
        ExclusiveAccessOkay = 2'd1,
        SlaveError          = 2'd2,
        DecodeError         = 2'd3
    } axi_resp_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_COLLECT,
        WR_DRAIN,
        REQ,
        WAIT_RSP,
        B_RESP,
        R_RESP
    } bridge_state_e;

    function automatic axi_resp_e resp_from_err(input logic err);
        return err ? SlaveError : Okay;
    endfunction

endpackage

// File: rtl/renode_axi_reg_bridge_timeout.sv
// Watchdog for the register port: counts cycles while enabled, flags expiry on the Limit-th cycle.
// Expiry is combinational on the counter; the count holds once expired and clears on clear.
module renode_axi_reg_bridge_timeout #(
    parameter int Limit = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] count;

    assign expired = enable && (count >= 16'(Limit - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/renode_axi_reg_bridge.sv
// AXI4 subordinate turning single-beat transfers into one register request; bursts drained with SLVERR.
// Latency: req_valid 1 cycle after the AW/W (or AR) handshake, B/R 1 cycle after rsp_valid.
// Backpressure: one transaction in flight; all channels stall until B/R retires. Watchdog: RENODE_AXI_REG_BRIDGE_TIMEOUT_EN.
module renode_axi_reg_bridge
    import renode_axi_pkg::*;
#(
    parameter int AddressWidth       = 32,
    parameter int DataWidth          = 32,
    parameter int TransactionIdWidth = 8,
    parameter int TimeoutCycles      = 256,
    localparam int StrobeWidth       = DataWidth / 8
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [TransactionIdWidth-1:0] awid,
    input  logic [AddressWidth-1:0]       awaddr,
    input  logic [7:0]                    awlen,
    input  logic [2:0]                    awsize,
    input  logic                          awvalid,
    output logic                          awready,
    input  logic [DataWidth-1:0]          wdata,
    input  logic [StrobeWidth-1:0]        wstrb,
    input  logic                          wlast,
    input  logic                          wvalid,
    output logic                          wready,
    output logic [TransactionIdWidth-1:0] bid,
    output logic [1:0]                    bresp,
    output logic                          bvalid,
    input  logic                          bready,
    input  logic [TransactionIdWidth-1:0] arid,
    input  logic [AddressWidth-1:0]       araddr,
    input  logic [7:0]                    arlen,
    input  logic [2:0]                    arsize,
    input  logic                          arvalid,
    output logic                          arready,
    output logic [TransactionIdWidth-1:0] rid,
    output logic [DataWidth-1:0]          rdata,
    output logic [1:0]                    rresp,
    output logic                          rlast,
    output logic                          rvalid,
    input  logic                          rready,
    output logic                          req_valid,
    output logic                          req_write,
    output logic [AddressWidth-1:0]       req_addr,
    output logic [DataWidth-1:0]          req_wdata,
    output logic [StrobeWidth-1:0]        req_strb,
    input  logic                          req_ready,
    input  logic                          rsp_valid,
    input  logic [DataWidth-1:0]          rsp_rdata,
    input  logic                          rsp_error
);

    bridge_state_e                 state;
    logic                          aw_got, w_got, wlast_q, last_read, cmd_write;
    logic [TransactionIdWidth-1:0] awid_q, arid_q;
    logic [AddressWidth-1:0]       addr_q;
    logic [DataWidth-1:0]          wdata_q;
    logic [StrobeWidth-1:0]        strb_q;
    logic [7:0]                    len_q, beat_cnt;
    logic                          timed_out;

    logic grant_write, grant_read, aw_hs, w_hs, aw_done, w_done, wlast_now;
    logic finish, fin_err;
    logic [7:0] len_now;

    logic unused;
    assign unused = ^{awsize, arsize};

    // Round-robin: last_read=1 means the read side was served last, so writes win ties.
    assign grant_write = (awvalid | wvalid) & (~arvalid | last_read);
    assign grant_read  = arvalid & ~grant_write;

    assign awready = (state == IDLE && grant_write) || (state == WR_COLLECT && !aw_got);
    assign wready  = (state == IDLE && grant_write) || (state == WR_COLLECT && !w_got)
                   || (state == WR_DRAIN);
    assign arready = (state == IDLE) && grant_read;

    assign aw_hs     = awvalid & awready;
    assign w_hs      = wvalid & wready;
    assign aw_done   = aw_got | aw_hs;
    assign w_done    = w_got | w_hs;
    assign len_now   = aw_hs ? awlen : len_q;
    assign wlast_now = w_hs ? wlast : wlast_q;

    // A watchdog expiry wins over a same-cycle response.
    assign finish  = ((state == REQ || state == WAIT_RSP) && timed_out)
                   || (state == WAIT_RSP && rsp_valid);
    assign fin_err = timed_out | rsp_error;

`ifdef RENODE_AXI_REG_BRIDGE_TIMEOUT_EN
    logic wd_run;
    assign wd_run = (state == REQ) || (state == WAIT_RSP);

    renode_axi_reg_bridge_timeout #(.Limit(TimeoutCycles)) u_timeout (
        .clk     (aclk),
        .reset   (areset),
        .clear   (!wd_run),
        .enable  (wd_run),
        .expired (timed_out)
    );
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            wlast_q   <= 1'b0;
            last_read <= 1'b1;
            cmd_write <= 1'b0;
            awid_q    <= '0;
            arid_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            req_valid <= 1'b0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_strb  <= '0;
            bid       <= '0;
            bresp     <= Okay;
            bvalid    <= 1'b0;
            rid       <= '0;
            rdata     <= '0;
            rresp     <= Okay;
            rlast     <= 1'b0;
            rvalid    <= 1'b0;
        end else begin
            case (state)
                IDLE, WR_COLLECT: begin
                    if (state == WR_COLLECT || grant_write) begin
                        last_read <= 1'b0;
                        cmd_write <= 1'b1;
                        if (aw_hs) begin
                            awid_q <= awid;
                            addr_q <= awaddr;
                            len_q  <= awlen;
                            aw_got <= 1'b1;
                        end
                        if (w_hs) begin
                            wdata_q <= wdata;
                            strb_q  <= wstrb;
                            wlast_q <= wlast;
                            w_got   <= 1'b1;
                        end
                        if (aw_done && len_now != 8'd0) begin
                            aw_got <= 1'b0;
                            w_got  <= 1'b0;
                            if (w_done && wlast_now) begin
                                state  <= B_RESP;
                                bvalid <= 1'b1;
                                bid    <= aw_hs ? awid : awid_q;
                                bresp  <= SlaveError;
                            end else begin
                                state <= WR_DRAIN;
                            end
                        end else if (aw_done && w_done) begin
                            aw_got    <= 1'b0;
                            w_got     <= 1'b0;
                            state     <= REQ;
                            req_valid <= 1'b1;
                            req_write <= 1'b1;
                            req_addr  <= aw_hs ? awaddr : addr_q;
                            req_wdata <= w_hs ? wdata : wdata_q;
                            req_strb  <= w_hs ? wstrb : strb_q;
                        end else begin
                            state <= WR_COLLECT;
                        end
                    end else if (grant_read) begin
                        arid_q    <= arid;
                        len_q     <= arlen;
                        last_read <= 1'b1;
                        cmd_write <= 1'b0;
                        beat_cnt  <= '0;
                        if (arlen == 8'd0) begin
                            state     <= REQ;
                            req_valid <= 1'b1;
                            req_write <= 1'b0;
                            req_addr  <= araddr;
                            req_wdata <= '0;
                            req_strb  <= '0;
                        end else begin
                            state  <= R_RESP;
                            rvalid <= 1'b1;
                            rid    <= arid;
                            rdata  <= '0;
                            rresp  <= SlaveError;
                            rlast  <= 1'b0;
                        end
                    end
                end
                WR_DRAIN: begin
                    if (w_hs && wlast) begin
                        state  <= B_RESP;
                        bvalid <= 1'b1;
                        bid    <= awid_q;
                        bresp  <= SlaveError;
                    end
                end
                REQ, WAIT_RSP: begin
                    if (finish) begin
                        req_valid <= 1'b0;
                        if (cmd_write) begin
                            state  <= B_RESP;
                            bvalid <= 1'b1;
                            bid    <= awid_q;
                            bresp  <= resp_from_err(fin_err);
                        end else begin
                            state  <= R_RESP;
                            rvalid <= 1'b1;
                            rid    <= arid_q;
                            rdata  <= timed_out ? '0 : rsp_rdata;
                            rresp  <= resp_from_err(fin_err);
                            rlast  <= 1'b1;
                        end
                    end else if (state == REQ && req_ready) begin
                        req_valid <= 1'b0;
                        state     <= WAIT_RSP;
                    end
                end
                B_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        bid    <= '0;
                        bresp  <= Okay;
                        state  <= IDLE;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        if (beat_cnt == len_q) begin
                            rvalid   <= 1'b0;
                            rlast    <= 1'b0;
                            rid      <= '0;
                            rdata    <= '0;
                            rresp    <= Okay;
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                            rlast    <= (beat_cnt + 8'd1 == len_q);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_renode_axi_reg_bridge.sv
// Scoreboard bench for renode_axi_reg_bridge: directed AXI traffic, a register-port responder,
// and a negedge monitor that pops expected req/B/R items on every handshake.
`timescale 1ns/1ps
module tb_renode_axi_reg_bridge;

    logic        aclk = 1'b0;
    logic        areset;
    logic [7:0]  awid, arid, bid, rid, awlen, arlen;
    logic [31:0] awaddr, araddr, wdata, rdata, req_addr, req_wdata, rsp_rdata;
    logic [2:0]  awsize, arsize;
    logic [3:0]  wstrb, req_strb;
    logic [1:0]  bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        req_valid, req_write, req_ready, rsp_valid, rsp_error;

    renode_axi_reg_bridge #(.TimeoutCycles(8)) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_strb(req_strb), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic write; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; } req_t;
    typedef struct { logic [7:0] id; logic [1:0] resp; } b_t;
    typedef struct { logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_t;
    typedef struct { logic [31:0] data; logic err; } rsp_t;

    req_t exp_req[$];
    b_t   exp_b[$];
    r_t   exp_r[$];
    rsp_t rsp_q[$];

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   req_rise = -1;
    int   b_rise = -1;
    bit   rsp_due = 0;
    rsp_t rsp_cur;
    logic req_valid_prev = 1'b0;
    logic bvalid_prev = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s: handshake seen with no expected item queued", name);
    endtask

    always @(posedge aclk) cyc++;

    // Monitor: every handshake consumes the oldest expectation of its channel.
    always @(negedge aclk) begin
        req_t er;
        b_t   eb;
        r_t   rr;
        if (req_valid && !req_valid_prev) req_rise = cyc;
        if (bvalid && !bvalid_prev) b_rise = cyc;
        req_valid_prev = req_valid;
        bvalid_prev    = bvalid;
        if (req_valid && req_ready) begin
            if (exp_req.size() == 0) unexpected("req");
            else begin
                er = exp_req.pop_front();
                check("req_write", req_write, er.write);
                check("req_addr", req_addr, er.addr);
                check("req_wdata", req_wdata, er.wdata);
                check("req_strb", req_strb, er.strb);
                if (rsp_q.size() > 0) begin
                    rsp_cur = rsp_q.pop_front();
                    rsp_due = 1;
                end
            end
        end
        if (bvalid && bready) begin
            if (exp_b.size() == 0) unexpected("b");
            else begin
                eb = exp_b.pop_front();
                check("bid", bid, eb.id);
                check("bresp", bresp, eb.resp);
            end
        end
        if (rvalid && rready) begin
            if (exp_r.size() == 0) unexpected("r");
            else begin
                rr = exp_r.pop_front();
                check("rid", rid, rr.id);
                check("rdata", rdata, rr.data);
                check("rresp", rresp, rr.resp);
                check("rlast", rlast, rr.last);
            end
        end
    end

    // Register port: answers one cycle after the request handshake, one cycle wide.
    initial begin
        rsp_valid = 0; rsp_rdata = 0; rsp_error = 0;
        forever begin
            @(posedge aclk); #1;
            if (rsp_due) begin
                rsp_valid = 1; rsp_rdata = rsp_cur.data; rsp_error = rsp_cur.err; rsp_due = 0;
            end else begin
                rsp_valid = 0; rsp_rdata = 0; rsp_error = 0;
            end
        end
    end

    task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awvalid = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge aclk);
            if (awready) begin @(posedge aclk); #1; awvalid = 0; return; end
        end
        tests++; fails++; awvalid = 0;
        $display("FAIL aw_handshake: awready not seen in 60 cycles, want it");
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        wdata = data; wstrb = strb; wlast = last; wvalid = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge aclk);
            if (wready) begin @(posedge aclk); #1; wvalid = 0; return; end
        end
        tests++; fails++; wvalid = 0;
        $display("FAIL w_handshake: wready not seen in 60 cycles, want it");
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arvalid = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge aclk);
            if (arready) begin @(posedge aclk); #1; arvalid = 0; return; end
        end
        tests++; fails++; arvalid = 0;
        $display("FAIL ar_handshake: arready not seen in 60 cycles, want it");
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_req.size() == 0 && exp_b.size() == 0 && exp_r.size() == 0) begin
                @(posedge aclk); #1;
                return;
            end
            @(posedge aclk); #1;
        end
        tests++; fails++;
        $display("FAIL %s: %0d req, %0d b, %0d r still outstanding, want 0",
                 name, exp_req.size(), exp_b.size(), exp_r.size());
        exp_req.delete(); exp_b.delete(); exp_r.delete(); rsp_q.delete();
    endtask

    task automatic check_quiet(input string name);
        check({name, "_ready_valid"}, {awready, wready, arready, bvalid, rvalid, req_valid}, 0);
        check({name, "_b"}, {bid, bresp}, 0);
        check({name, "_r"}, {rid, rdata, rresp, rlast}, 0);
        check({name, "_req"}, {req_write, req_addr, req_wdata, req_strb}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        areset = 1; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awvalid = 0;
        wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 1;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arvalid = 0; rready = 1; req_ready = 1;
        repeat (3) @(posedge aclk);
        #1 areset = 0;
        @(negedge aclk);
        check_quiet("reset");
        @(posedge aclk); #1;

        // Single write, AW one cycle ahead of W.
        exp_req.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 4'hF});
        rsp_q.push_back('{32'h0, 1'b0});
        exp_b.push_back('{8'h03, 2'd0});
        fork
            send_aw(8'h03, 32'h10, 8'd0);
            begin @(posedge aclk); #1; send_w(32'hDEADBEEF, 4'hF, 1'b1); end
        join
        wait_done("write_single");

        // W ahead of AW; register error -> SLVERR.
        exp_req.push_back('{1'b1, 32'h30, 32'h0000BEEF, 4'h3});
        rsp_q.push_back('{32'h0, 1'b1});
        exp_b.push_back('{8'h0A, 2'd2});
        fork
            send_w(32'h0000BEEF, 4'h3, 1'b1);
            begin @(posedge aclk); #1; send_aw(8'h0A, 32'h30, 8'd0); end
        join
        wait_done("write_w_first");

        // Single read with req_ready held low for a few cycles.
        req_ready = 0;
        exp_req.push_back('{1'b0, 32'h24, 32'h0, 4'h0});
        rsp_q.push_back('{32'h12345678, 1'b1});
        exp_r.push_back('{8'h05, 32'h12345678, 2'd2, 1'b1});
        fork
            send_ar(8'h05, 32'h24, 8'd0);
            begin repeat (4) @(posedge aclk); #1; req_ready = 1; end
        join
        wait_done("read_single");

        // Write and read contending, twice: write must win each time.
        exp_req.push_back('{1'b1, 32'h40, 32'hA5A50001, 4'h3});
        exp_req.push_back('{1'b0, 32'h44, 32'h0, 4'h0});
        rsp_q.push_back('{32'h0, 1'b0});
        rsp_q.push_back('{32'h0BADF00D, 1'b0});
        exp_b.push_back('{8'h01, 2'd0});
        exp_r.push_back('{8'h02, 32'h0BADF00D, 2'd0, 1'b1});
        fork
            send_aw(8'h01, 32'h40, 8'd0);
            send_w(32'hA5A50001, 4'h3, 1'b1);
            send_ar(8'h02, 32'h44, 8'd0);
        join
        wait_done("contend_1");
        exp_req.push_back('{1'b1, 32'h48, 32'h5A5A0002, 4'hC});
        exp_req.push_back('{1'b0, 32'h4C, 32'h0, 4'h0});
        rsp_q.push_back('{32'h0, 1'b0});
        rsp_q.push_back('{32'hCAFE0004, 1'b1});
        exp_b.push_back('{8'h03, 2'd0});
        exp_r.push_back('{8'h04, 32'hCAFE0004, 2'd2, 1'b1});
        fork
            send_aw(8'h03, 32'h48, 8'd0);
            send_w(32'h5A5A0002, 4'hC, 1'b1);
            send_ar(8'h04, 32'h4C, 8'd0);
        join
        wait_done("contend_2");

        // Read burst of 4: SLVERR beats, rlast on the 4th only, no register request.
        for (int i = 0; i < 4; i++) exp_r.push_back('{8'h07, 32'h0, 2'd2, (i == 3)});
        send_ar(8'h07, 32'h80, 8'd3);
        wait_done("read_burst");

        // Write burst of 2: both beats drained, single SLVERR B.
        exp_b.push_back('{8'h09, 2'd2});
        fork
            send_aw(8'h09, 32'h90, 8'd1);
            begin send_w(32'h11111111, 4'hF, 1'b0); send_w(32'h22222222, 4'hF, 1'b1); end
        join
        wait_done("write_burst");

        // B held by bready=0, then reset mid-transaction.
        bready = 0;
        exp_req.push_back('{1'b1, 32'h50, 32'h00000055, 4'h1});
        rsp_q.push_back('{32'h0, 1'b0});
        fork
            send_aw(8'h04, 32'h50, 8'd0);
            send_w(32'h00000055, 4'h1, 1'b1);
        join
        for (int i = 0; i < 20 && !bvalid; i++) @(posedge aclk);
        repeat (5) @(posedge aclk);
        @(negedge aclk);
        check("held_bvalid", bvalid, 1'b1);
        check("held_bid", bid, 8'h04);
        @(posedge aclk); #1 areset = 1;
        @(posedge aclk); #1 areset = 0;
        @(negedge aclk);
        check_quiet("mid_reset");
        bready = 1;
        @(posedge aclk); #1;
        exp_req.push_back('{1'b1, 32'h58, 32'h00000066, 4'hF});
        rsp_q.push_back('{32'h0, 1'b0});
        exp_b.push_back('{8'h0B, 2'd0});
        fork
            send_aw(8'h0B, 32'h58, 8'd0);
            send_w(32'h00000066, 4'hF, 1'b1);
        join
        wait_done("after_reset");

`ifdef RENODE_AXI_REG_BRIDGE_TIMEOUT_EN
        // Register never answers: SLVERR 8 cycles after req_valid rises.
        exp_req.push_back('{1'b1, 32'h60, 32'h00000077, 4'hF});
        exp_b.push_back('{8'h06, 2'd2});
        fork
            send_aw(8'h06, 32'h60, 8'd0);
            send_w(32'h00000077, 4'hF, 1'b1);
        join
        wait_done("timeout");
        check("timeout_latency", b_rise - req_rise, 8);
`endif

        repeat (3) @(posedge aclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/renode_axi_reg_bridge.md
# renode_axi_reg_bridge

Synthesizable AXI4 subordinate that accepts transactions issued by the Renode AXI manager and converts each into one request/response on a simple register-bank port. Sits directly downstream of the manager, between the co-simulated AXI bus and peripheral register logic. Single-beat transfers are serviced. Bursts are drained and answered with SLVERR.

## Interface
- AddressWidth, 32, AXI and register address width
- DataWidth, 32, AXI and register data width; StrobeWidth = DataWidth/8 (derived, not overridable)
- TransactionIdWidth, 8, AXI ID width
- TimeoutCycles, 256, watchdog limit in cycles (used only with the timeout feature)
- aclk  in  1  bus clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- awid/awaddr/awlen/awsize/awvalid  in  ID/Addr/8/3/1  write address; awready  out  1
- wdata/wstrb/wlast/wvalid  in  Data/Strobe/1/1  write data; wready  out  1
- bid/bresp/bvalid  out  ID/2/1  write response; bready  in  1
- arid/araddr/arlen/arsize/arvalid  in  ID/Addr/8/3/1  read address; arready  out  1
- rid/rdata/rresp/rlast/rvalid  out  ID/Data/2/1/1  read data; rready  in  1
- req_valid/req_write/req_addr/req_wdata/req_strb  out  1/1/Addr/Data/Strobe  register request; req_ready  in  1
- rsp_valid/rsp_rdata/rsp_error  in  1/Data/1  register response, one cycle wide

## Operation
- FSM states: IDLE, WR_COLLECT, WR_DRAIN, REQ, WAIT_RSP, B_RESP, R_RESP.
- IDLE arbitration:
  - Read pending = arvalid. Write pending = awvalid|wvalid.
  - If both are pending, grant by round-robin using a last-served flag. The flag resets to "read", so write wins first.
  - arready = IDLE & grant_read. awready and wready are asserted while in IDLE with grant_write, or in WR_COLLECT until the respective channel has been captured.
  - awready, wready and arready are combinational from state, the captured flags and the valids. All other outputs are registered.
- Write path:
  - AW and W are captured independently, in either order or in the same cycle.
  - When both are captured with awlen==0, the FSM moves to REQ.
  - If awlen!=0, the FSM moves to WR_DRAIN. It accepts W beats (wready=1) until wlast, then goes to B_RESP with SLVERR and issues no register request.
- Read path:
  - AR with arlen==0 goes to REQ.
  - AR with arlen!=0 goes to R_RESP with SLVERR. It returns arlen+1 beats, rdata=0, with rlast on the final beat, counted by an 8-bit beat counter.
- REQ:
  - req_valid=1, with req_addr and req_write from the captured command.
  - req_wdata and req_strb come from the captured W beat; both are 0 for reads.
  - Request fields are held stable until req_ready, then the FSM moves to WAIT_RSP.
- WAIT_RSP:
  - On rsp_valid, capture rsp_rdata and rsp_error.
  - Response code = SLVERR (2) if rsp_error, else OKAY (0).
  - Go to B_RESP (write) or R_RESP (read).
- B_RESP: bid = captured awid. Hold until bready, then return to IDLE.
- R_RESP: rid = captured arid, rlast=1. Hold until rready, then return to IDLE.
- awsize/arsize are not checked; strobes pass through unmodified.
- EXOKAY (1) and DECERR (3) are never generated.

## Timing
- Reset values: all valid/ready outputs 0, all data/ID/resp outputs 0, FSM IDLE, captured flags clear, beat counter 0, last-served = read.
- areset asserted mid-transaction: return to IDLE next edge and drop any in-flight request or response. The upstream manager is reset simultaneously, so no response is owed.
- Latency, single-beat write, AW and W handshaked at edge N:
  - req_valid high from N+1.
  - With req_ready=1 at N+1 and rsp_valid at N+2, bvalid is high from N+3.
- Latency, single-beat read: same as write, with rvalid in place of bvalid.
- rsp_valid arriving in the same cycle as the req handshake is ignored; the register port must respond at least one cycle later.
- rsp_valid outside WAIT_RSP is ignored.
- Burst read beats: one per cycle while rready=1. The beat counter reaches arlen exactly on the rlast beat.

## Configuration
- RENODE_AXI_REG_BRIDGE_TIMEOUT_EN defined:
  - A 16-bit counter runs in REQ and WAIT_RSP and clears on entry to REQ.
  - At TimeoutCycles the FSM drops req_valid and goes to B_RESP or R_RESP with SLVERR.
  - Late rsp_valid is then ignored.
- Undefined: no counter; the bridge waits indefinitely for req_ready and rsp_valid.

## Structure
- renode_axi_pkg holds the response code enum (Okay=0, ExclusiveAccessOkay=1, SlaveError=2, DecodeError=3) and the bridge FSM state enum.
- One sub-module: renode_axi_reg_bridge_timeout, the watchdog counter with clear/enable/expired. It is instantiated only under the macro.

## Test plan
- Write addr 0x10, data 0xDEADBEEF, strb 0xF, id 0x3, with AW one cycle before W → one req with write=1, addr 0x10, data 0xDEADBEEF; bid=0x3, bresp=0.
- Read addr 0x24, id 0x5; register replies rdata 0x12345678, error=1 → rid=0x5, rdata 0x12345678, rresp=2, rlast=1.
- AW and AR both valid in the same cycle, twice in a row → write served first, then read; exactly one req at a time.
- AR with arlen=3 → four R beats, rresp=2, rlast only on the 4th, no req; write awlen=1 → two W beats accepted, one B with SLVERR.
- Hold bready=0 for 5 cycles, then assert areset for 1 cycle → all outputs 0 and state IDLE on the next edge; a subsequent write completes normally.
- With the macro defined, TimeoutCycles=8 and rsp_valid never asserted → bresp=2 exactly 8 cycles after req_valid rises.
